mac_tile_sequencer: RTL and testbench

Sequences one decoded matrix-multiply command across the systolic MAC array and the unified buffer. It accepts the registered fields from instruction decode (op, V/U/ITER dims, UB read/write start addresses) through a valid/ready handshake. It then runs ITER_dim tiles, and each tile has three phases: read operands, drain the array pipeline, write results. It drives unified-buffer read/write enables and addresses plus the MAC enable, and reports busy, done and error status to the top-level control.

---
 rtl/mac_tile_sequencer.sv | 125 ++++++++++++
 tb/tb_mac_tile_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_sequencer.sv
// Walks one decoded matmul command through ITER tiles of read / drain / write,
// driving unified-buffer strobes and the MAC enable.
module mac_tile_sequencer #(
    parameter int          DIM_W     = 7,
    parameter int          ADDR_W    = 12,
    parameter logic [2:0]  OP_MATMUL = 3'b010
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        MAC_op_i,
    input  logic [DIM_W-1:0]  V_dim_i,
    input  logic [DIM_W-1:0]  U_dim_i,
    input  logic [DIM_W-1:0]  ITER_dim_i,
    input  logic [ADDR_W-1:0] ub_rd_start_i,
    input  logic [ADDR_W-1:0] ub_wr_start_i,
    input  logic              stall_i,
    output logic              ub_rd_en_o,
    output logic [ADDR_W-1:0] ub_rd_addr_o,
    output logic              ub_wr_en_o,
    output logic [ADDR_W-1:0] ub_wr_addr_o,
    output logic              mac_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [DIM_W-1:0]  u_reg, v_reg, iter_dim_reg;
    logic [DIM_W-1:0]  row_cnt_reg, drain_cnt_reg, iter_cnt_reg;
    logic [ADDR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic              err_reg;

    logic accept, cmd_ok, active;
    logic row_last, drain_last, iter_last;

    assign accept     = cmd_valid_i && (state_reg == IDLE);
    assign cmd_ok     = (MAC_op_i == OP_MATMUL) && (U_dim_i != '0) &&
                        (V_dim_i != '0) && (ITER_dim_i != '0);
    assign active     = !stall_i;
    // Counters compare against dim-1 so a 127 dimension never needs a wider counter.
    assign row_last   = (row_cnt_reg == u_reg - DIM_ONE);
    assign drain_last = (drain_cnt_reg == v_reg - DIM_ONE);
    assign iter_last  = (iter_cnt_reg == iter_dim_reg - DIM_ONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = cmd_ok ? READ : DONE;
            READ:    if (active && row_last) state_next = DRAIN;
            DRAIN:   if (active && drain_last) state_next = WRITE;
            WRITE:   if (active && row_last) state_next = iter_last ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready_o  = (state_reg == IDLE);
    assign busy_o       = (state_reg != IDLE);
    assign done_o       = (state_reg == DONE);
    assign err_o        = err_reg;
    assign ub_rd_en_o   = (state_reg == READ) && active;
    assign ub_wr_en_o   = (state_reg == WRITE) && active;
    assign mac_en_o     = ((state_reg == READ) || (state_reg == DRAIN)) && active;
    assign ub_rd_addr_o = rd_ptr_reg;
    assign ub_wr_addr_o = wr_ptr_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            u_reg         <= '0;
            v_reg         <= '0;
            iter_dim_reg  <= '0;
            row_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            iter_cnt_reg  <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        u_reg         <= U_dim_i;
                        v_reg         <= V_dim_i;
                        iter_dim_reg  <= ITER_dim_i;
                        rd_ptr_reg    <= ub_rd_start_i;
                        wr_ptr_reg    <= ub_wr_start_i;
                        row_cnt_reg   <= '0;
                        drain_cnt_reg <= '0;
                        iter_cnt_reg  <= '0;
                        err_reg       <= !cmd_ok;
                    end
                end
                READ: begin
                    if (active) begin
                        rd_ptr_reg  <= rd_ptr_reg + ADDR_ONE;
                        row_cnt_reg <= row_last ? '0 : row_cnt_reg + DIM_ONE;
                    end
                end
                DRAIN: begin
                    if (active)
                        drain_cnt_reg <= drain_last ? '0 : drain_cnt_reg + DIM_ONE;
                end
                WRITE: begin
                    if (active) begin
                        wr_ptr_reg  <= wr_ptr_reg + ADDR_ONE;
                        row_cnt_reg <= row_last ? '0 : row_cnt_reg + DIM_ONE;
                        if (row_last && !iter_last)
                            iter_cnt_reg <= iter_cnt_reg + DIM_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed bench for mac_tile_sequencer: records strobe events per command
// and compares them with hand-computed cycle/address tables.
module tb_mac_tile_sequencer;

    localparam int DIM_W  = 7;
    localparam int ADDR_W = 12;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [2:0]        MAC_op_i;
    logic [DIM_W-1:0]  V_dim_i, U_dim_i, ITER_dim_i;
    logic [ADDR_W-1:0] ub_rd_start_i, ub_wr_start_i;
    logic              stall_i;
    logic              ub_rd_en_o, ub_wr_en_o, mac_en_o;
    logic [ADDR_W-1:0] ub_rd_addr_o, ub_wr_addr_o;
    logic              busy_o, done_o, err_o;

    always #5 clk_i = ~clk_i;

    mac_tile_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .MAC_op_i(MAC_op_i), .V_dim_i(V_dim_i), .U_dim_i(U_dim_i), .ITER_dim_i(ITER_dim_i),
        .ub_rd_start_i(ub_rd_start_i), .ub_wr_start_i(ub_wr_start_i),
        .stall_i(stall_i),
        .ub_rd_en_o(ub_rd_en_o), .ub_rd_addr_o(ub_rd_addr_o),
        .ub_wr_en_o(ub_wr_en_o), .ub_wr_addr_o(ub_wr_addr_o),
        .mac_en_o(mac_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Observed events, encoded as cycle*4096 + address
    int rd_ev[16], wr_ev[16], done_ev[4], acc_ev[4];
    int n_rd, n_wr, n_done, n_acc, n_mac, n_bad;
    logic ready_at[64], err_at[64];
    logic [31:0] snap;

    int e_rd[16], e_wr[16], e_done[4];
    int en_rd, en_wr, en_done, e_mac;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int enc(input int c, input int a);
        return c * 4096 + a;
    endfunction

    function automatic logic [31:0] outputs_now();
        return {1'b0, cmd_ready_o, busy_o, done_o, err_o, ub_rd_en_o, ub_wr_en_o,
                mac_en_o, ub_rd_addr_o, ub_wr_addr_o};
    endfunction

    task automatic set_cmd(input logic [2:0] op, input int u, input int v, input int it,
                           input int rd, input int wr);
        MAC_op_i      = op;
        U_dim_i       = DIM_W'(u);
        V_dim_i       = DIM_W'(v);
        ITER_dim_i    = DIM_W'(it);
        ub_rd_start_i = ADDR_W'(rd);
        ub_wr_start_i = ADDR_W'(wr);
        cmd_valid_i   = 1'b1;
    endtask

    // Cycle 0 is the cycle in which the command is presented with ready high.
    task automatic run(input int nc, input logic [63:0] stall_mask, input logic [63:0] rst_mask,
                       input bit hold_valid, input int snap_c);
        n_rd = 0; n_wr = 0; n_done = 0; n_acc = 0; n_mac = 0; n_bad = 0;
        snap = '0;
        for (int c = 0; c < nc; c++) begin
            stall_i = stall_mask[c];
            rst_i   = rst_mask[c];
            if (c > 0 && !hold_valid) cmd_valid_i = 1'b0;
            @(negedge clk_i);
            if (ub_rd_en_o && n_rd < 16) begin rd_ev[n_rd] = enc(c, int'(ub_rd_addr_o)); n_rd++; end
            if (ub_wr_en_o && n_wr < 16) begin wr_ev[n_wr] = enc(c, int'(ub_wr_addr_o)); n_wr++; end
            if (done_o && n_done < 4) begin done_ev[n_done] = c; n_done++; end
            if (cmd_valid_i && cmd_ready_o && n_acc < 4) begin acc_ev[n_acc] = c; n_acc++; end
            if (mac_en_o) n_mac++;
            if (stall_i && (ub_rd_en_o || ub_wr_en_o || mac_en_o)) n_bad++;
            ready_at[c] = cmd_ready_o;
            err_at[c]   = err_o;
            if (c == snap_c) snap = outputs_now();
            @(posedge clk_i);
            #1;
        end
        stall_i = 1'b0;
        rst_i   = 1'b0;
    endtask

    task automatic verify(input string tag);
        check_eq({tag, " rd_count"}, n_rd, en_rd);
        for (int i = 0; i < en_rd && i < n_rd; i++)
            check_eq($sformatf("%s rd[%0d]", tag, i), rd_ev[i], e_rd[i]);
        check_eq({tag, " wr_count"}, n_wr, en_wr);
        for (int i = 0; i < en_wr && i < n_wr; i++)
            check_eq($sformatf("%s wr[%0d]", tag, i), wr_ev[i], e_wr[i]);
        check_eq({tag, " done_count"}, n_done, en_done);
        for (int i = 0; i < en_done && i < n_done; i++)
            check_eq($sformatf("%s done[%0d]", tag, i), done_ev[i], e_done[i]);
        check_eq({tag, " mac_cycles"}, n_mac, e_mac);
        check_eq({tag, " strobes_in_stall"}, n_bad, 0);
        $display("[TB] %s: %0d reads, %0d writes, %0d done pulses", tag, n_rd, n_wr, n_done);
    endtask

    task automatic expect_basic();
        en_rd = 4; en_wr = 4; en_done = 1; e_mac = 10;
        e_rd[0] = enc(1, 'h010); e_rd[1] = enc(2, 'h011);
        e_rd[2] = enc(8, 'h012); e_rd[3] = enc(9, 'h013);
        e_wr[0] = enc(6, 'h200); e_wr[1] = enc(7, 'h201);
        e_wr[2] = enc(13, 'h202); e_wr[3] = enc(14, 'h203);
        e_done[0] = 15;
    endtask

    task automatic expect_wrap();
        en_rd = 2; en_wr = 2; en_done = 1; e_mac = 3;
        e_rd[0] = enc(1, 'hFFF); e_rd[1] = enc(2, 'h000);
        e_wr[0] = enc(4, 'hFFE); e_wr[1] = enc(5, 'hFFF);
        e_done[0] = 6;
    endtask

    task automatic expect_error();
        en_rd = 0; en_wr = 0; en_done = 1; e_mac = 0;
        e_done[0] = 1;
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; stall_i = 1'b0;
        MAC_op_i = '0; U_dim_i = '0; V_dim_i = '0; ITER_dim_i = '0;
        ub_rd_start_i = '0; ub_wr_start_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("reset outputs", outputs_now(), {1'b0, 7'b1000000, 24'h0});
        @(posedge clk_i); #1;

        set_cmd(3'b010, 2, 3, 2, 'h010, 'h200);
        run(17, 64'd0, 64'd0, 1'b0, -1);
        expect_basic(); verify("basic");
        check_eq("basic ready_at_15", ready_at[15], 1'b0);
        check_eq("basic ready_at_16", ready_at[16], 1'b1);
        check_eq("basic err", err_at[16], 1'b0);

        set_cmd(3'b010, 2, 3, 2, 'h010, 'h200);
        run(19, (64'd1 << 2) | (64'd1 << 6), 64'd0, 1'b0, -1);
        en_rd = 4; en_wr = 4; en_done = 1; e_mac = 10;
        e_rd[0] = enc(1, 'h010); e_rd[1] = enc(3, 'h011);
        e_rd[2] = enc(10, 'h012); e_rd[3] = enc(11, 'h013);
        e_wr[0] = enc(8, 'h200); e_wr[1] = enc(9, 'h201);
        e_wr[2] = enc(15, 'h202); e_wr[3] = enc(16, 'h203);
        e_done[0] = 17;
        verify("stall");

        set_cmd(3'b001, 2, 3, 2, 'h010, 'h200);
        run(3, 64'd0, 64'd0, 1'b0, -1);
        expect_error(); verify("bad_op");
        check_eq("bad_op err_before", err_at[0], 1'b0);
        check_eq("bad_op err_at_done", err_at[1], 1'b1);
        check_eq("bad_op err_sticky", err_at[2], 1'b1);

        set_cmd(3'b010, 0, 3, 2, 'h010, 'h200);
        run(3, 64'd0, 64'd0, 1'b0, -1);
        expect_error(); verify("zero_u");
        check_eq("zero_u err_at_done", err_at[1], 1'b1);

        set_cmd(3'b010, 2, 1, 1, 'hFFF, 'hFFE);
        run(8, 64'd0, 64'd0, 1'b0, -1);
        expect_wrap(); verify("wrap");
        check_eq("wrap err_held_until_accept", err_at[0], 1'b1);
        check_eq("wrap err_cleared", err_at[1], 1'b0);

        set_cmd(3'b010, 2, 3, 2, 'h010, 'h200);
        run(12, 64'd0, 64'd1 << 7, 1'b0, 8);
        en_rd = 2; en_wr = 2; en_done = 0; e_mac = 5;
        e_rd[0] = enc(1, 'h010); e_rd[1] = enc(2, 'h011);
        e_wr[0] = enc(6, 'h200); e_wr[1] = enc(7, 'h201);
        verify("reset_midop");
        check_eq("reset_midop outputs_c8", snap, {1'b0, 7'b1000000, 24'h0});

        set_cmd(3'b010, 2, 1, 1, 'hFFF, 'hFFE);
        run(8, 64'd0, 64'd0, 1'b0, -1);
        expect_wrap(); verify("after_reset");

        set_cmd(3'b010, 2, 1, 1, 'hFFF, 'hFFE);
        run(14, 64'd0, 64'd0, 1'b1, -1);
        cmd_valid_i = 1'b0;
        en_rd = 4; en_wr = 4; en_done = 2; e_mac = 6;
        e_rd[0] = enc(1, 'hFFF); e_rd[1] = enc(2, 'h000);
        e_rd[2] = enc(8, 'hFFF); e_rd[3] = enc(9, 'h000);
        e_wr[0] = enc(4, 'hFFE); e_wr[1] = enc(5, 'hFFF);
        e_wr[2] = enc(11, 'hFFE); e_wr[3] = enc(12, 'hFFF);
        e_done[0] = 6; e_done[1] = 13;
        verify("handshake");
        check_eq("handshake accept_count", n_acc, 2);
        if (n_acc >= 2) begin
            check_eq("handshake accept0", acc_ev[0], 0);
            check_eq("handshake accept1", acc_ev[1], 7);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 time units");
        $fatal(1);
    end

endmodule
